// File: rtl/hex_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_port_pkg
// Description : Shared register offsets, control bits and segment constants
//               for the seven-segment display port.
// Revision    : 1.0
// ============================================================================
package hex_port_pkg;

    localparam int          c_DIGIT_CNT = 6;
    localparam logic [2:0]  c_CTRL_OFF  = 3'd6;

    localparam int          c_DEC_BIT   = 0;
    localparam int          c_BLK_BIT   = 1;

    // Segment bit order: bit0 = a ... bit6 = g
    localparam int          c_SEG_A     = 0;
    localparam int          c_SEG_G     = 6;
    localparam int          c_SEG_W     = c_SEG_G - c_SEG_A + 1;

    localparam logic [6:0]  c_BLANK     = 7'h7F;

endpackage : hex_port_pkg
`default_nettype wire

// File: rtl/hex_port_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_port_if
// Description : Processor data-bus view of the display port (address, write
//               data, write strobe and registered read-back).
// Revision    : 1.0
// ============================================================================
interface hex_port_if;

    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] RDATA;

    modport master (
        output ADDR,
        output DOUT,
        output W,
        input  RDATA
    );

    modport slave (
        input  ADDR,
        input  DOUT,
        input  W,
        output RDATA
    );

endinterface : hex_port_if
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational 4-bit to seven-segment decoder, active-high
//               segments, full 0-F table.
// Revision    : 1.0
// ============================================================================
module seg7_decoder
    import hex_port_pkg::*;
(
    input  logic [3:0]                 i_nibble,
    output logic [c_SEG_G:c_SEG_A]     o_seg
);

    always_comb begin
        o_seg = '0;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = '0;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/hex_port.sv
`default_nettype none
// ============================================================================
// Module      : hex_port
// Description : Memory-mapped six-digit seven-segment port with hex decode,
//               raw-segment mode, whole-display blink and registered read-back.
// Revision    : 1.0
// ============================================================================
module hex_port
    import hex_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int          BLINK_DIV = 25000000,
    parameter int          CNT_W     = 25
) (
    input  logic       Clock,
    input  logic       Resetn,
    hex_port_if.slave  bus,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [15:0]        w_off;
    logic               w_hit;
    logic               w_wr;
    logic               w_ctrl_wr;
    logic [15:0]        w_rdata;

    logic [c_SEG_W-1:0] r_digit [c_DIGIT_CNT];
    logic [c_SEG_W-1:0] w_pat   [c_DIGIT_CNT];
    logic [6:0]         r_hex   [c_DIGIT_CNT];
    logic               r_dec;
    logic               r_blk;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_blank;

    // Addresses below BASE wrap to large offsets and fall out of range.
    assign w_off     = bus.ADDR - BASE_ADDR;
    assign w_hit     = (w_off < 16'd7);
    assign w_wr      = bus.W && w_hit;
    assign w_ctrl_wr = w_wr && (w_off[2:0] == c_CTRL_OFF);

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            if (w_off[2:0] == c_CTRL_OFF) begin
                w_rdata = {14'b0, r_blk, r_dec};
            end else begin
                w_rdata = {9'b0, r_digit[w_off[2:0]]};
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < c_DIGIT_CNT; k++) begin
                r_digit[k] <= '0;
            end
            r_dec     <= 1'b0;
            r_blk     <= 1'b0;
            bus.RDATA <= '0;
        end else begin
            bus.RDATA <= w_rdata;
            for (int k = 0; k < c_DIGIT_CNT; k++) begin
                if (w_wr && (w_off[2:0] == 3'(k))) begin
                    r_digit[k] <= bus.DOUT[6:0];
                end
            end
            if (w_ctrl_wr) begin
                r_dec <= bus.DOUT[c_DEC_BIT];
                r_blk <= bus.DOUT[c_BLK_BIT];
            end
        end
    end

    // Any control write that is not BLK 1->1 restarts the blink from visible.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt   <= '0;
            r_blank <= 1'b0;
        end else if (w_ctrl_wr && !(r_blk && bus.DOUT[c_BLK_BIT])) begin
            r_cnt   <= '0;
            r_blank <= 1'b0;
        end else if (r_blk) begin
            if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_blank <= ~r_blank;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < c_DIGIT_CNT; k++) begin : g_digit
        logic [c_SEG_W-1:0] w_dec_seg;

        seg7_decoder u_dec (
            .i_nibble (r_digit[k][3:0]),
            .o_seg    (w_dec_seg)
        );

        assign w_pat[k] = r_dec ? w_dec_seg : r_digit[k];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < c_DIGIT_CNT; k++) begin
                r_hex[k] <= c_BLANK;
            end
        end else begin
            for (int k = 0; k < c_DIGIT_CNT; k++) begin
                r_hex[k] <= r_blank ? c_BLANK : ~w_pat[k];
            end
        end
    end

    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];

endmodule : hex_port
`default_nettype wire

// File: tb/tb_hex_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_port
// Description : Directed self-checking bench for hex_port (BLINK_DIV = 4).
// Revision    : 1.0
// ============================================================================
module tb_hex_port;

    localparam logic [15:0] c_BASE = 16'h2000;

    logic       clk;
    logic       rst_n;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [15:0] r_rd;

    int n_total = 0;
    int n_bad   = 0;

    hex_port_if bus ();

    hex_port #(
        .BASE_ADDR (c_BASE),
        .BLINK_DIV (4),
        .CNT_W     (3)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus),
        .HEX0   (hex0),
        .HEX1   (hex1),
        .HEX2   (hex2),
        .HEX3   (hex3),
        .HEX4   (hex4),
        .HEX5   (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.ADDR = a;
        bus.DOUT = d;
        bus.W    = 1'b1;
        tick();
        bus.W    = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.ADDR = a;
        bus.W    = 1'b0;
        tick();
        d = bus.RDATA;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.ADDR = '0;
        bus.DOUT = '0;
        bus.W    = 1'b0;
        #23 rst_n = 1'b1;
        tick();
        check("rst_hex0", {9'b0, hex0}, 16'h007F);
        check("rst_hex5", {9'b0, hex5}, 16'h007F);
        check("rst_rdata", bus.RDATA, 16'h0000);
        rd(c_BASE + 16'd6, r_rd);
        check("rd_ctrl_rst", r_rd, 16'h0000);

        // Decode mode
        wr(c_BASE + 16'd6, 16'h0001);
        wr(c_BASE + 16'd0, 16'h0005);
        check("hex0_latency", {9'b0, hex0}, 16'h0040);
        tick();
        check("dec_hex0_5", {9'b0, hex0}, 16'h0012);
        wr(c_BASE + 16'd5, 16'h000A);
        tick();
        check("dec_hex5_A", {9'b0, hex5}, 16'h0008);
        wr(c_BASE + 16'd1, 16'hFFF0);
        tick();
        check("dec_hex1_lownib", {9'b0, hex1}, 16'h0040);

        // Raw mode
        wr(c_BASE + 16'd6, 16'h0000);
        wr(c_BASE + 16'd3, 16'h007F);
        tick();
        check("raw_hex3_7F", {9'b0, hex3}, 16'h0000);
        check("raw_hex0_05", {9'b0, hex0}, 16'h007A);
        wr(c_BASE + 16'd3, 16'hFF80);
        tick();
        check("raw_hex3_80", {9'b0, hex3}, 16'h007F);
        rd(c_BASE + 16'd3, r_rd);
        check("rd_d3_masked", r_rd, 16'h0000);

        // Read-back and out-of-range
        wr(c_BASE + 16'd2, 16'h1234);
        rd(c_BASE + 16'd2, r_rd);
        check("rd_d2", r_rd, 16'h0034);
        wr(c_BASE + 16'd7, 16'hFFFF);
        wr(16'h1000, 16'hFFFF);
        rd(c_BASE + 16'd7, r_rd);
        check("rd_base7", r_rd, 16'h0000);
        rd(16'h1000, r_rd);
        check("rd_1000", r_rd, 16'h0000);
        rd(c_BASE + 16'd6, r_rd);
        check("rd_ctrl_unchg", r_rd, 16'h0000);
        rd(c_BASE + 16'd2, r_rd);
        check("rd_d2_unchg", r_rd, 16'h0034);
        check("hex2_unchg", {9'b0, hex2}, 16'h004B);

        // Same-edge write and read
        bus.ADDR = c_BASE + 16'd2;
        bus.DOUT = 16'h0055;
        bus.W    = 1'b1;
        tick();
        bus.W    = 1'b0;
        check("rbw_old", bus.RDATA, 16'h0034);
        tick();
        check("rbw_new", bus.RDATA, 16'h0055);

        // Blink: BLK set at edge t, visible t+1..t+4, blank t+5..t+8
        wr(c_BASE + 16'd6, 16'h0003);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("blink_p%0d", i), {9'b0, hex0},
                  (i <= 4) ? 16'h0012 : 16'h007F);
        end
        check("blink_hex5_blank", {9'b0, hex5}, 16'h007F);
        wr(c_BASE + 16'd0, 16'h0008);           // edge t+6, during blank
        check("blank_wr_t6", {9'b0, hex0}, 16'h007F);
        tick();
        check("blank_wr_t7", {9'b0, hex0}, 16'h007F);
        tick();
        check("blank_wr_t8", {9'b0, hex0}, 16'h007F);
        tick();
        check("blank_wr_vis", {9'b0, hex0}, 16'h0000);
        check("blank_hex5_vis", {9'b0, hex5}, 16'h0008);
        for (int i = 10; i <= 13; i++) begin
            tick();
            check($sformatf("blink_p%0d", i), {9'b0, hex0},
                  (i <= 12) ? 16'h0000 : 16'h007F);
        end
        wr(c_BASE + 16'd6, 16'h0001);           // clear BLK at t+14
        check("clr_blk_t", {9'b0, hex0}, 16'h007F);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("clr_blk_steady%0d", i), {9'b0, hex0}, 16'h0000);
        end

        // Reset mid-blink
        wr(c_BASE + 16'd6, 16'h0003);
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_blank", {9'b0, hex0}, 16'h007F);
        check("pre_rst_rdata", bus.RDATA, 16'h0003);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdata", bus.RDATA, 16'h0000);
        check("mid_rst_hex3", {9'b0, hex3}, 16'h007F);
        #3 rst_n = 1'b1;
        rd(c_BASE + 16'd6, r_rd);
        check("post_rst_ctrl", r_rd, 16'h0000);
        rd(c_BASE + 16'd0, r_rd);
        check("post_rst_d0", r_rd, 16'h0000);
        check("post_rst_hex0", {9'b0, hex0}, 16'h007F);
        wr(c_BASE + 16'd0, 16'h0046);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("post_rst_steady%0d", i), {9'b0, hex0}, 16'h0039);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_hex_port
`default_nettype wire
